// File: rtl/key_conditioner.sv
// key_conditioner: per-key synchroniser, debouncer, edge pulses and auto-repeat steps
module key_conditioner #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_step
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW = $clog2(MX + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DL_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RR_LAST = TW'(REPEAT_RATE - 1);
  localparam logic REL_RAW = (ACTIVE_LOW != 0);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic s1, s2, ps, lvl, prs, rls, stp, acc;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmr;
    state_t st;
    assign ps  = s2 ^ REL_RAW;
    assign acc = (ps != lvl) && (cnt == DB_LAST);
    // two-flop synchroniser, idles at the released pin level
    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        s1 <= REL_RAW;
        s2 <= REL_RAW;
      end else begin
        s1 <= key_raw[k];
        s2 <= s1;
      end
    end
    // debounce: accept a new level once it has been stable long enough
    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        lvl <= 1'b0;
        cnt <= '0;
        prs <= 1'b0;
        rls <= 1'b0;
      end else begin
        prs <= acc && ps;
        rls <= acc && !ps;
        if (ps == lvl) cnt <= '0;
        else if (acc) begin
          lvl <= ps;
          cnt <= '0;
        end else cnt <= cnt + CW'(1);
      end
    end
    // repeat FSM: step on press, after the initial delay, then at the repeat rate
    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        st  <= IDLE;
        tmr <= '0;
        stp <= 1'b0;
      end else begin
        stp <= 1'b0;
        case (st)
          IDLE: if (acc && ps) begin
            stp <= 1'b1;
            tmr <= '0;
            st  <= DELAY;
          end
          DELAY: if (acc && !ps) begin
            tmr <= '0;
            st  <= IDLE;
          end else if (tmr == DL_LAST) begin
            stp <= 1'b1;
            tmr <= '0;
            st  <= REPEAT;
          end else tmr <= tmr + TW'(1);
          REPEAT: if (acc && !ps) begin
            tmr <= '0;
            st  <= IDLE;
          end else if (tmr == RR_LAST) begin
            stp <= 1'b1;
            tmr <= '0;
          end else tmr <= tmr + TW'(1);
          default: begin
            tmr <= '0;
            st  <= IDLE;
          end
        endcase
      end
    end
    assign key_level[k]   = lvl;
    assign key_press[k]   = prs;
    assign key_release[k] = rls;
    assign key_step[k]    = stp;
  end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: randomized and directed checks of both pin polarities against a timing model
module tb_key_conditioner;
  localparam int D = 4, RD = 10, RR = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] pr = 2'b00;
  logic [1:0] lvl_lo, prs_lo, rls_lo, stp_lo, lvl_hi, prs_hi, rls_hi, stp_hi;
  int n_tests = 0, n_fail = 0;
  bit live = 1'b0;
  always #5 clk = ~clk;
  key_conditioner #(.N_KEYS(2), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .ACTIVE_LOW(1)) u_lo (
    .CLOCK_50(clk), .reset(rst), .key_raw(~pr),
    .key_level(lvl_lo), .key_press(prs_lo), .key_release(rls_lo), .key_step(stp_lo));
  key_conditioner #(.N_KEYS(2), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .ACTIVE_LOW(0)) u_hi (
    .CLOCK_50(clk), .reset(rst), .key_raw(pr),
    .key_level(lvl_hi), .key_press(prs_hi), .key_release(rls_hi), .key_step(stp_hi));
  // model: raw seen two edges late, level flips after D differing samples, steps by age since press
  bit d1 [2], d2 [2], ml [2], mp [2], mr [2], ms [2];
  int run [2], age [2];
  logic [1:0] e_lvl, e_prs, e_rls, e_stp;
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        d1[k] = 0; d2[k] = 0; ml[k] = 0; mp[k] = 0; mr[k] = 0; ms[k] = 0;
        run[k] = 0; age[k] = 0;
      end else begin
        bit ps;
        ps = d2[k]; d2[k] = d1[k]; d1[k] = pr[k];
        mp[k] = 0; mr[k] = 0;
        if (ps != ml[k]) begin
          run[k]++;
          if (run[k] == D) begin
            ml[k] = ps; run[k] = 0; mp[k] = ps; mr[k] = !ps;
          end
        end else run[k] = 0;
        if (mp[k]) age[k] = 0;
        else age[k]++;
        ms[k] = ml[k] && (age[k] == 0 || (age[k] >= RD && (age[k] - RD) % RR == 0));
      end
      e_lvl[k] = ml[k]; e_prs[k] = mp[k]; e_rls[k] = mr[k]; e_stp[k] = ms[k];
    end
  end
  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask
  task automatic drive(input logic [1:0] p, input logic r, input int n);
    repeat (n) begin
      @(negedge clk);
      if (live) begin
        check("level_lo", lvl_lo, e_lvl); check("press_lo", prs_lo, e_prs);
        check("release_lo", rls_lo, e_rls); check("step_lo", stp_lo, e_stp);
        check("level_hi", lvl_hi, e_lvl); check("press_hi", prs_hi, e_prs);
        check("release_hi", rls_hi, e_rls); check("step_hi", stp_hi, e_stp);
      end
      pr = p;
      rst = r;
    end
  endtask
  initial begin
    @(posedge clk);
    live = 1'b1;
    drive(2'b00, 1'b1, 3);
    drive(2'b00, 1'b0, 5);
    drive(2'b01, 1'b0, 20);
    drive(2'b00, 1'b0, 20);
    repeat (3) begin
      drive(2'b01, 1'b0, 2);
      drive(2'b00, 1'b0, 2);
    end
    drive(2'b01, 1'b0, 20);
    drive(2'b00, 1'b0, 20);
    drive(2'b01, 1'b0, 45);
    drive(2'b00, 1'b0, 20);
    for (int h = 6; h <= 22; h++) begin
      drive(2'b01, 1'b0, h);
      drive(2'b00, 1'b0, 12);
    end
    drive(2'b01, 1'b0, 25);
    drive(2'b01, 1'b1, 2);
    drive(2'b01, 1'b0, 30);
    drive(2'b00, 1'b0, 15);
    drive(2'b11, 1'b0, 25);
    drive(2'b00, 1'b0, 15);
    drive(2'b10, 1'b0, 30);
    drive(2'b00, 1'b0, 15);
    for (int s = 0; s < 200; s++) begin
      logic [1:0] p;
      p = 2'($urandom_range(0, 3));
      drive(p, ($urandom_range(0, 29) == 0), 1);
      drive(p, 1'b0, $urandom_range(1, 25));
    end
    drive(2'b00, 1'b0, 20);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
